// File: rtl/branch_resolve_bht.sv
// ============================================================================
//  Module   : branch_resolve_bht
//  Purpose  : B-type branch resolution with a 2-bit-counter branch history
//             table and saturating branch/mispredict performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_bht #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   i_fe_pc,
    output logic              o_fe_pred_taken,
    input  logic              i_br_valid,
    input  logic [2:0]        i_br_funct3,
    input  logic [XLEN-1:0]   i_br_pc,
    input  logic [XLEN-1:0]   i_br_rs1,
    input  logic [XLEN-1:0]   i_br_rs2,
    input  logic              i_br_pred_taken,
    output logic              o_res_valid,
    output logic              o_res_taken,
    output logic              o_res_mispredict,
    output logic              o_res_illegal,
    output logic [PERF_W-1:0] o_perf_branches,
    output logic [PERF_W-1:0] o_perf_mispredicts
);

    localparam int c_IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]         r_bht [BHT_DEPTH];
    logic               r_res_valid;
    logic               r_res_taken;
    logic               r_res_mispredict;
    logic               r_res_illegal;
    logic [PERF_W-1:0]  r_perf_branches;
    logic [PERF_W-1:0]  r_perf_mispredicts;

    logic [c_IDX_W-1:0] w_fe_idx;
    logic [c_IDX_W-1:0] w_br_idx;
    logic               w_eq;
    logic               w_lt_s;
    logic               w_lt_u;
    logic               w_cond;
    logic               w_illegal;
    logic               w_upd;
    logic               w_mispredict;
    logic [1:0]         w_cnt_cur;
    logic [1:0]         w_cnt_next;
    logic               w_unused_pc;

    assign w_fe_idx = i_fe_pc[c_IDX_W+1:2];
    assign w_br_idx = i_br_pc[c_IDX_W+1:2];
    assign w_unused_pc = ^{i_fe_pc[XLEN-1:c_IDX_W+2], i_fe_pc[1:0],
                           i_br_pc[XLEN-1:c_IDX_W+2], i_br_pc[1:0]};

    // Read-before-write: the table is only written at the edge, so a lookup
    // colliding with an update naturally sees the old counter.
    assign o_fe_pred_taken = r_bht[w_fe_idx][1];

    assign w_eq      = (i_br_rs1 == i_br_rs2);
    assign w_lt_s    = ($signed(i_br_rs1) < $signed(i_br_rs2));
    assign w_lt_u    = (i_br_rs1 < i_br_rs2);
    assign w_illegal = (i_br_funct3[2:1] == 2'b01);

    always_comb begin
        w_cond = 1'b0;
        case (i_br_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt_s;
            3'b101:  w_cond = ~w_lt_s;
            3'b110:  w_cond = w_lt_u;
            3'b111:  w_cond = ~w_lt_u;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_upd        = i_br_valid & ~w_illegal;
    assign w_mispredict = w_upd & (w_cond != i_br_pred_taken);

    always_comb begin
        w_cnt_cur  = r_bht[w_br_idx];
        w_cnt_next = w_cnt_cur;
        if (w_cond) begin
            if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'd1;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CNT_INIT;
        end else if (w_upd) begin
            r_bht[w_br_idx] <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid        <= 1'b0;
            r_res_taken        <= 1'b0;
            r_res_mispredict   <= 1'b0;
            r_res_illegal      <= 1'b0;
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else begin
            r_res_valid      <= i_br_valid;
            r_res_taken      <= w_upd & w_cond;
            r_res_mispredict <= w_mispredict;
            r_res_illegal    <= i_br_valid & w_illegal;
            if (w_upd && (r_perf_branches != '1))
                r_perf_branches <= r_perf_branches + PERF_W'(1);
            if (w_mispredict && (r_perf_mispredicts != '1))
                r_perf_mispredicts <= r_perf_mispredicts + PERF_W'(1);
        end
    end

    assign o_res_valid        = r_res_valid;
    assign o_res_taken        = r_res_taken;
    assign o_res_mispredict   = r_res_mispredict;
    assign o_res_illegal      = r_res_illegal;
    assign o_perf_branches    = r_perf_branches;
    assign o_perf_mispredicts = r_perf_mispredicts;

endmodule

`default_nettype wire

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Next-generation branch unit for the RV32/RV64 core; XLEN-parametrised.
- Resolves B-type conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) and registers the outcome.
- Flags mispredictions against the fetch-side guess.
- Holds a DEPTH-entry table of 2-bit saturating counters that supplies a taken/not-taken prediction to fetch; also keeps branch and mispredict performance counters.

Parameters:
XLEN, 32, operand and PC width (32 or 64)
BHT_DEPTH, 64, number of predictor entries; power of 2, min 2
CNT_INIT, 2'b01, reset value of every predictor counter (weakly not-taken)
PERF_W, 32, width of performance counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
fe_pc  in  XLEN  fetch PC for prediction lookup
fe_pred_taken  out  1  combinational prediction for fe_pc
br_valid  in  1  branch present in resolve stage this cycle
br_funct3  in  3  B-type funct3
br_pc  in  XLEN  PC of resolving branch
br_rs1  in  XLEN  operand 1
br_rs2  in  XLEN  operand 2
br_pred_taken  in  1  prediction fetch used for this branch
res_valid  out  1  registered: result valid
res_taken  out  1  registered: branch taken
res_mispredict  out  1  registered: res_taken != br_pred_taken
res_illegal  out  1  registered: funct3 010 or 011
perf_branches  out  PERF_W  legal branches resolved
perf_mispredicts  out  PERF_W  mispredicted legal branches

Behaviour:
- Reset: asserting rst_n low asynchronously sets all res_* outputs and both perf counters to 0 and all BHT entries to CNT_INIT. A mid-operation reset drops any in-flight result; no update from that cycle lands.
- Index: idx = pc[log2(BHT_DEPTH)+1 : 2]. pc[1:0] is ignored.
- Prediction: fe_pred_taken = bht[idx(fe_pc)][1]. Purely combinational.
- Conditions (decided at funct3):
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed rs1<rs2
  - 101 BGE: signed rs1>=rs2
  - 110 BLTU: unsigned rs1<rs2
  - 111 BGEU: unsigned rs1>=rs2
  - 010/011: illegal
- Latency: exactly 1 cycle. Results for a br_valid at edge N appear on res_* after edge N and hold for one cycle. With br_valid=0, res_valid=0 and res_taken/res_mispredict/res_illegal=0 the next cycle.
- Legal branch at edge N:
  - res_valid=1, res_taken=condition, res_mispredict=(condition != br_pred_taken), res_illegal=0.
  - BHT entry idx(br_pc) updates: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - perf_branches +1; perf_mispredicts +1 if mispredicted.
- Illegal funct3: res_valid=1, res_illegal=1, res_taken=0, res_mispredict=0. No BHT update; no perf increment.
- Perf counters saturate at all-ones and never wrap.
- Read/write collision: when fe_pc and br_pc map to the same idx in the same cycle, fe_pred_taken returns the pre-update value (read-before-write). The new value is visible from the next cycle.
- One update per cycle; back-to-back br_valid to the same idx must accumulate correctly (2 taken from state 01 gives 11).
- No stall/flush input; the upstream pipeline gates br_valid.

Test Plan:
- Reset: hold rst_n=0 then release → fe_pred_taken=0 for all fe_pc; perf_*=0; res_valid=0.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=0x00000001 (XLEN=32). BLT → res_taken=1; BLTU → 0; BGE → 0; BGEU → 1. Each appears one cycle after br_valid.
- Training: 3× taken BEQ (rs1=rs2=5) at br_pc=0x100 with br_pred_taken=0 → counter 01→10→11→11 (saturates); res_mispredict=1,1,1; perf_branches=3, perf_mispredicts=3; fe_pc=0x100 then predicts 1. Then one not-taken → counter 10, prediction still 1.
- Collision: fe_pc=br_pc=0x104 with counter 01 and taken branch → fe_pred_taken=0 in that cycle, 1 in the next.
- Illegal funct3=010 with br_valid=1 → res_valid=1, res_illegal=1, res_taken=0; BHT and perf counters unchanged.
- Async reset mid-stream: assert rst_n low between clock edges right after a br_valid edge → res_valid drops immediately, BHT entries return to 01, perf_*=0; PERF_W=4 bench shows saturation at 15 after 20 mispredicts.
